// File: rtl/wb_bus_arbiter.sv
// rtl/wb_bus_arbiter.sv - two-master round-robin Wishbone arbiter with bus-timeout ERR guard
`timescale 1ns/1ps
module wb_bus_arbiter #(
  parameter int unsigned TIMEOUT_CYCLES = 16,
  parameter logic [31:0] ERR_DATA       = 32'hDEAD_DEAD
) (
  input  logic        wb_clk_i,
  input  logic        wb_rst_i,
  input  logic        m0_cyc_i,
  input  logic        m0_stb_i,
  input  logic        m0_we_i,
  input  logic [3:0]  m0_sel_i,
  input  logic [31:0] m0_adr_i,
  input  logic [31:0] m0_dat_i,
  output logic [31:0] m0_dat_o,
  output logic        m0_ack_o,
  output logic        m0_err_o,
  input  logic        m1_cyc_i,
  input  logic        m1_stb_i,
  input  logic        m1_we_i,
  input  logic [3:0]  m1_sel_i,
  input  logic [31:0] m1_adr_i,
  input  logic [31:0] m1_dat_i,
  output logic [31:0] m1_dat_o,
  output logic        m1_ack_o,
  output logic        m1_err_o,
  output logic        s_cyc_o,
  output logic        s_stb_o,
  output logic        s_we_o,
  output logic [3:0]  s_sel_o,
  output logic [31:0] s_adr_o,
  output logic [31:0] s_dat_o,
  input  logic [31:0] s_dat_i,
  input  logic        s_ack_i,
  output logic [1:0]  grant_o
);

  typedef enum logic [1:0] {IDLE, BUSY, ABORT, DRAIN} state_t;

  localparam logic [15:0] CNT_TERM = 16'(TIMEOUT_CYCLES - 1);

  state_t      state, state_nxt;
  logic [1:0]  grant, grant_nxt;
  logic        last, last_nxt;
  logic [15:0] cnt, cnt_nxt;

  logic        req0, req1;
  logic        g_cyc, g_stb, g_we;
  logic [3:0]  g_sel;
  logic [31:0] g_adr, g_dat;
  logic        ack, err;
  logic [31:0] rdat;

  assign req0 = m0_cyc_i & m0_stb_i;
  assign req1 = m1_cyc_i & m1_stb_i;

  // Granted master's signals; only meaningful while grant is non-zero.
  assign g_cyc = grant[1] ? m1_cyc_i : m0_cyc_i;
  assign g_stb = grant[1] ? m1_stb_i : m0_stb_i;
  assign g_we  = grant[1] ? m1_we_i  : m0_we_i;
  assign g_sel = grant[1] ? m1_sel_i : m0_sel_i;
  assign g_adr = grant[1] ? m1_adr_i : m0_adr_i;
  assign g_dat = grant[1] ? m1_dat_i : m0_dat_i;

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      state <= IDLE;
      grant <= 2'b00;
      last  <= 1'b1;
      cnt   <= 16'd0;
    end else begin
      state <= state_nxt;
      grant <= grant_nxt;
      last  <= last_nxt;
      cnt   <= cnt_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    grant_nxt = grant;
    last_nxt  = last;
    cnt_nxt   = cnt;
    s_cyc_o   = 1'b0;
    s_stb_o   = 1'b0;
    s_we_o    = 1'b0;
    s_sel_o   = 4'h0;
    s_adr_o   = 32'h0;
    s_dat_o   = 32'h0;
    ack       = 1'b0;
    err       = 1'b0;
    rdat      = 32'h0;
    unique case (state)
      IDLE: begin
        grant_nxt = 2'b00;
        cnt_nxt   = 16'd0;
        // On a tie, the master that was not served last wins.
        if (req0 && (!req1 || last)) begin
          grant_nxt = 2'b01;
          last_nxt  = 1'b0;
          state_nxt = BUSY;
        end else if (req1) begin
          grant_nxt = 2'b10;
          last_nxt  = 1'b1;
          state_nxt = BUSY;
        end
      end
      BUSY: begin
        s_cyc_o = g_cyc;
        s_stb_o = g_stb;
        s_we_o  = g_we;
        s_sel_o = g_sel;
        s_adr_o = g_adr;
        s_dat_o = g_dat;
        ack     = s_ack_i;
        rdat    = s_dat_i;
        cnt_nxt = (g_stb && !s_ack_i) ? cnt + 16'd1 : 16'd0;
        if (!g_cyc) begin
          state_nxt = IDLE;
          grant_nxt = 2'b00;
        end else if (g_stb && !s_ack_i && cnt == CNT_TERM) begin
          state_nxt = ABORT;
        end
      end
      ABORT: begin
        err     = 1'b1;
        rdat    = ERR_DATA;
        cnt_nxt = 16'd0;
        if (!g_cyc) begin
          state_nxt = IDLE;
          grant_nxt = 2'b00;
        end else begin
          state_nxt = DRAIN;
        end
      end
      DRAIN: begin
        if (!g_cyc) begin
          state_nxt = IDLE;
          grant_nxt = 2'b00;
        end
      end
      default: begin
        state_nxt = IDLE;
        grant_nxt = 2'b00;
      end
    endcase
  end

  assign m0_ack_o = ack & grant[0];
  assign m0_err_o = err & grant[0];
  assign m0_dat_o = grant[0] ? rdat : 32'h0;
  assign m1_ack_o = ack & grant[1];
  assign m1_err_o = err & grant[1];
  assign m1_dat_o = grant[1] ? rdat : 32'h0;
  assign grant_o  = grant;

endmodule
